// File: rtl/mb16_acc_pkg.sv
// Shared types and helpers for the mb16_acc accumulation stage.
package mb16_acc_pkg;

  // Per-issue marker travelling alongside the multiplier pipeline.
  typedef struct packed {
    logic valid;
    logic last;
  } mb16_tag_t;

  // Accumulator width: full product width plus guard bits.
  function automatic int unsigned acc_width(input int unsigned width,
                                            input int unsigned guard);
    return 2 * width + guard;
  endfunction

endpackage

// File: rtl/mb16_acc_if.sv
// Feeder/consumer bus of mb16_acc: issue handshake, product input and
// result register with valid/ready handshake.
interface mb16_acc_if
  import mb16_acc_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GUARD = 8,
  parameter int unsigned LEN_W = 16
);
  localparam int unsigned ACC_W = acc_width(WIDTH, GUARD);

  logic                 in_valid;
  logic                 in_last;
  logic                 in_ready;
  logic [2*WIDTH-1:0]   product;
  logic [ACC_W-1:0]     acc_out;
  logic [LEN_W-1:0]     acc_count;
  logic                 acc_ovf;
  logic                 acc_valid;
  logic                 acc_ready;

  // Feeder + consumer side.
  modport master (
    output in_valid, in_last, product, acc_ready,
    input  in_ready, acc_out, acc_count, acc_ovf, acc_valid
  );

  // Accumulator side.
  modport slave (
    input  in_valid, in_last, product, acc_ready,
    output in_ready, acc_out, acc_count, acc_ovf, acc_valid
  );
endinterface

// File: rtl/mb16_tag_pipe.sv
// LAT-deep tag shift register matched to the multiplier latency.
// Presents the tail tag and whether any in-flight tag closes a vector.
module mb16_tag_pipe
  import mb16_acc_pkg::*;
#(
  parameter int unsigned LAT = 3
) (
  input  logic      CLK,
  input  logic      RST,
  input  mb16_tag_t tag_in,
  output mb16_tag_t tag_out,
  output logic      pend_last
);

  mb16_tag_t stage [LAT];

  // Shift tags one stage per cycle; reset drops every in-flight tag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= tag_in;
      for (int unsigned i = 1; i < LAT; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign tag_out = stage[LAT-1];

  // Any valid last tag still in flight, including the one at the tail.
  always_comb begin
    pend_last = 1'b0;
    for (int unsigned i = 0; i < LAT; i++) begin
      pend_last = pend_last | (stage[i].valid & stage[i].last);
    end
  end

endmodule

// File: rtl/mb16_acc.sv
// mb16_acc: dot-product accumulator placed behind the mb16_top multiplier.
// Tags follow each issue through a LAT-deep pipeline; the tail tag decides
// whether the current product is accumulated and whether it ends a vector.
// Optional build macro MB16_ACC_SATURATE_EN: accumulator clamps to
// all-ones on carry-out instead of wrapping.
module mb16_acc
  import mb16_acc_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LAT   = 3,
  parameter int unsigned GUARD = 8,
  parameter int unsigned LEN_W = 16
) (
  input logic        CLK,
  input logic        RST,
  mb16_acc_if.slave  bus
);

  localparam int unsigned ACC_W = acc_width(WIDTH, GUARD);
  localparam int unsigned SUM_W = ACC_W + 1;

  mb16_tag_t        tag_in;
  mb16_tag_t        tag_tail;
  logic             pend_last;
  logic             ready;
  logic             issue;

  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] cnt;
  logic             ovf;

  logic [ACC_W-1:0] acc_out_q;
  logic [LEN_W-1:0] acc_count_q;
  logic             acc_ovf_q;
  logic             acc_valid_q;

  logic [SUM_W-1:0] sum;
  logic             carry;
  logic [ACC_W-1:0] acc_next;
  logic [LEN_W-1:0] cnt_next;

  // Blocking on a pending last keeps the output register free for its commit.
  assign ready        = !acc_valid_q && !pend_last;
  assign issue        = bus.in_valid && ready;
  assign bus.in_ready = ready;

  // Tag entering the pipeline this cycle.
  always_comb begin
    tag_in       = '0;
    tag_in.valid = issue;
    tag_in.last  = issue && bus.in_last;
  end

  mb16_tag_pipe #(.LAT(LAT)) u_tag_pipe (
    .CLK       (CLK),
    .RST       (RST),
    .tag_in    (tag_in),
    .tag_out   (tag_tail),
    .pend_last (pend_last)
  );

  // Running sum with carry-out, and the saturating element counter.
  always_comb begin
    sum   = {1'b0, acc} + SUM_W'(bus.product);
    carry = sum[ACC_W];
`ifdef MB16_ACC_SATURATE_EN
    acc_next = carry ? '1 : sum[ACC_W-1:0];
`else
    acc_next = sum[ACC_W-1:0];
`endif
    cnt_next = (cnt == '1) ? cnt : cnt + LEN_W'(1);
  end

  // Running accumulator state; cleared when a vector commits.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (tag_tail.valid) begin
      if (tag_tail.last) begin
        acc <= '0;
        cnt <= '0;
        ovf <= 1'b0;
      end else begin
        acc <= acc_next;
        cnt <= cnt_next;
        ovf <= ovf | carry;
      end
    end
  end

  // One-entry result register with valid/ready handshake.
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_out_q   <= '0;
      acc_count_q <= '0;
      acc_ovf_q   <= 1'b0;
      acc_valid_q <= 1'b0;
    end else if (tag_tail.valid && tag_tail.last) begin
      acc_out_q   <= acc_next;
      acc_count_q <= cnt_next;
      acc_ovf_q   <= ovf | carry;
      acc_valid_q <= 1'b1;
    end else if (acc_valid_q && bus.acc_ready) begin
      acc_valid_q <= 1'b0;
    end
  end

  assign bus.acc_out   = acc_out_q;
  assign bus.acc_count = acc_count_q;
  assign bus.acc_ovf   = acc_ovf_q;
  assign bus.acc_valid = acc_valid_q;

endmodule
